btb_update_scheduler: RTL and testbench

// Collects branch-resolution updates from two execute-stage requesters (branch ALU, jump unit) and

---
 rtl/btb_update_scheduler_pkg.sv | 21 ++
 rtl/btb_update_scheduler_if.sv | 48 ++++
 rtl/btb_update_scheduler_fifo.sv | 46 ++++
 rtl/btb_update_scheduler.sv | 124 ++++++++++++
 tb/tb_btb_update_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/btb_update_scheduler_pkg.sv
// Shared types and sizing for the BTB update scheduler: command layout, FSM states
// and the BTB geometry used by the invalidate sweep.
package btb_pkg;

  localparam int NUM_SETS   = 16;
  localparam int SET_IDX_W  = $clog2(NUM_SETS);
  localparam int ADDR_W     = 32;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic {
    IDLE,
    SWEEP
  } sched_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] target;
    logic              taken;
  } btb_upd_t;

endpackage

// File: rtl/btb_update_scheduler_if.sv
// Bundle of the two requester ports, the invalidate-all control and the BTB-side
// update/invalidate ports. The scheduler sits on the slave side.
interface btb_update_scheduler_if;
  import btb_pkg::*;

  logic                 req0_valid;
  logic                 req0_ready;
  logic [ADDR_W-1:0]    req0_pc;
  logic [ADDR_W-1:0]    req0_target;
  logic                 req0_taken;

  logic                 req1_valid;
  logic                 req1_ready;
  logic [ADDR_W-1:0]    req1_pc;
  logic [ADDR_W-1:0]    req1_target;
  logic                 req1_taken;

  logic                 inv_all_req;
  logic                 inv_all_busy;

  logic                 upd_valid;
  logic                 upd_ready;
  logic [ADDR_W-1:0]    upd_pc;
  logic [ADDR_W-1:0]    upd_target;
  logic                 upd_taken;

  logic                 inv_valid;
  logic [SET_IDX_W-1:0] inv_set;

  modport master (
    output req0_valid, req0_pc, req0_target, req0_taken,
    output req1_valid, req1_pc, req1_target, req1_taken,
    output inv_all_req, upd_ready,
    input  req0_ready, req1_ready, inv_all_busy,
    input  upd_valid, upd_pc, upd_target, upd_taken,
    input  inv_valid, inv_set
  );

  modport slave (
    input  req0_valid, req0_pc, req0_target, req0_taken,
    input  req1_valid, req1_pc, req1_target, req1_taken,
    input  inv_all_req, upd_ready,
    output req0_ready, req1_ready, inv_all_busy,
    output upd_valid, upd_pc, upd_target, upd_taken,
    output inv_valid, inv_set
  );

endinterface

// File: rtl/btb_update_scheduler_fifo.sv
// Small synchronous FIFO of BTB update commands with a synchronous flush.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module btb_upd_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     clear,
  input  logic     push,
  input  btb_upd_t push_data,
  input  logic     pop,
  output btb_upd_t head,
  output logic     full,
  output logic     empty
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  btb_upd_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; occupancy is governed entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[IDX_W-1:0]] <= push_data;
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                 (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
  assign head  = mem[rd_ptr[IDX_W-1:0]];

endmodule

// File: rtl/btb_update_scheduler.sv
// Serialises branch-resolution updates from two requesters onto the single BTB
// update port with round-robin arbitration, and runs a full-BTB invalidate sweep.
module btb_update_scheduler
  import btb_pkg::*;
(
  input logic                    clk,
  input logic                    reset,
  btb_update_scheduler_if.slave  bus
);

  sched_state_e         state;
  logic [SET_IDX_W-1:0] set_cnt;
  logic                 busy_q;
  logic                 inv_valid_q;
  logic                 rr_ptr;
  logic                 hold;
  logic                 hold_grant;

  btb_upd_t push0_data, push1_data;
  btb_upd_t head0, head1, cmd;
  logic     full0, full1, empty0, empty1;
  logic     idle, ready0, ready1, push0, push1, pop0, pop1;
  logic     upd_valid, upd_fire, grant, sweep_start;

  assign idle        = (state == IDLE);
  assign ready0      = !full0 && idle && !reset;
  assign ready1      = !full1 && idle && !reset;
  assign push0       = bus.req0_valid && ready0;
  assign push1       = bus.req1_valid && ready1;
  assign sweep_start = idle && bus.inv_all_req;

  assign push0_data = '{pc: bus.req0_pc, target: bus.req0_target, taken: bus.req0_taken};
  assign push1_data = '{pc: bus.req1_pc, target: bus.req1_target, taken: bus.req1_taken};

  btb_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk       (clk),
    .reset     (reset),
    .clear     (sweep_start),
    .push      (push0),
    .push_data (push0_data),
    .pop       (pop0),
    .head      (head0),
    .full      (full0),
    .empty     (empty0)
  );

  btb_upd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk       (clk),
    .reset     (reset),
    .clear     (sweep_start),
    .push      (push1),
    .push_data (push1_data),
    .pop       (pop1),
    .head      (head1),
    .full      (full1),
    .empty     (empty1)
  );

  // A stalled command keeps its grant even if the other FIFO fills in meanwhile.
  always_comb begin
    grant = 1'b0;
    if (hold)                  grant = hold_grant;
    else if (!empty0 && !empty1) grant = rr_ptr;
    else                       grant = empty0;
  end

  assign upd_valid = idle && !(empty0 && empty1);
  assign upd_fire  = upd_valid && bus.upd_ready;
  assign pop0      = upd_fire && !grant;
  assign pop1      = upd_fire && grant;
  assign cmd       = grant ? head1 : head0;

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= 1'b0;
      hold       <= 1'b0;
      hold_grant <= 1'b0;
    end else begin
      if (upd_fire) rr_ptr <= ~grant;
      hold       <= upd_valid && !bus.upd_ready && !sweep_start;
      hold_grant <= grant;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      set_cnt     <= '0;
      busy_q      <= 1'b0;
      inv_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.inv_all_req) begin
            state       <= SWEEP;
            busy_q      <= 1'b1;
            inv_valid_q <= 1'b1;
          end
        end
        SWEEP: begin
          if (set_cnt == SET_IDX_W'(NUM_SETS - 1)) begin
            set_cnt     <= '0;
            state       <= IDLE;
            busy_q      <= 1'b0;
            inv_valid_q <= 1'b0;
          end else begin
            set_cnt <= set_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.req0_ready   = ready0;
  assign bus.req1_ready   = ready1;
  assign bus.upd_valid    = upd_valid;
  assign bus.upd_pc       = cmd.pc;
  assign bus.upd_target   = cmd.target;
  assign bus.upd_taken    = cmd.taken;
  assign bus.inv_valid    = inv_valid_q;
  assign bus.inv_set      = set_cnt;
  assign bus.inv_all_busy = busy_q;

endmodule

// File: tb/tb_btb_update_scheduler.sv
// Self-checking bench for btb_update_scheduler: directed scenarios plus a randomized
// run compared against a queue-based reference model of the scheduling rules.
module tb_btb_update_scheduler;
  import btb_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  btb_update_scheduler_if bus();

  btb_update_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: one queue per requester plus sweep progress.
  btb_upd_t q0[$];
  btb_upd_t q1[$];
  logic     m_sweep;
  int       m_cnt;
  logic     m_rr;
  logic     m_hold;
  logic     m_hold_g;

  logic     exp_upd_valid, exp_grant, exp_rdy0, exp_rdy1;
  btb_upd_t exp_cmd;

  function void predict();
    exp_upd_valid = !m_sweep && (q0.size() > 0 || q1.size() > 0);
    if (m_hold)                               exp_grant = m_hold_g;
    else if (q0.size() > 0 && q1.size() > 0)  exp_grant = m_rr;
    else                                      exp_grant = (q0.size() == 0);
    exp_cmd = '0;
    if (exp_upd_valid) exp_cmd = exp_grant ? q1[0] : q0[0];
    exp_rdy0 = !reset && !m_sweep && (q0.size() < FIFO_DEPTH);
    exp_rdy1 = !reset && !m_sweep && (q1.size() < FIFO_DEPTH);
  endfunction

  task automatic tick();
    btb_upd_t e0, e1;
    logic v0, v1, rdy, inv;
    predict();
    e0  = '{pc: bus.req0_pc, target: bus.req0_target, taken: bus.req0_taken};
    e1  = '{pc: bus.req1_pc, target: bus.req1_target, taken: bus.req1_taken};
    v0  = bus.req0_valid;
    v1  = bus.req1_valid;
    rdy = bus.upd_ready;
    inv = bus.inv_all_req;
    @(posedge clk);
    if (reset) begin
      q0.delete(); q1.delete();
      m_sweep = 1'b0; m_cnt = 0; m_rr = 1'b0; m_hold = 1'b0; m_hold_g = 1'b0;
    end else if (m_sweep) begin
      if (m_cnt == NUM_SETS - 1) begin
        m_cnt = 0;
        m_sweep = 1'b0;
      end else begin
        m_cnt++;
      end
    end else begin
      if (exp_upd_valid && rdy) begin
        if (exp_grant) void'(q1.pop_front());
        else           void'(q0.pop_front());
        m_rr = !exp_grant;
      end
      m_hold   = exp_upd_valid && !rdy;
      m_hold_g = exp_grant;
      if (v0 && exp_rdy0) q0.push_back(e0);
      if (v1 && exp_rdy1) q1.push_back(e1);
      if (inv) begin
        m_sweep = 1'b1;
        q0.delete(); q1.delete();
        m_hold = 1'b0;
      end
    end
    #1;
  endtask

  task automatic drive_idle();
    bus.req0_valid = 1'b0; bus.req0_pc = '0; bus.req0_target = '0; bus.req0_taken = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_pc = '0; bus.req1_target = '0; bus.req1_taken = 1'b0;
    bus.inv_all_req = 1'b0;
    bus.upd_ready   = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.req0_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_ready_during: got %b expected 0", bus.req0_ready); end
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if (bus.upd_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_upd_valid: got %b expected 0", bus.upd_valid); end
    n_checks++;
    if (bus.inv_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_inv_valid: got %b expected 0", bus.inv_valid); end
    n_checks++;
    if (bus.inv_all_busy !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.inv_all_busy); end
    n_checks++;
    if (bus.inv_set !== '0) begin n_fails++; $display("[TB] FAIL reset_inv_set: got %0d expected 0", bus.inv_set); end
    n_checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b11) begin n_fails++; $display("[TB] FAIL reset_ready_after: got %b expected 11", {bus.req0_ready, bus.req1_ready}); end
  endtask

  task automatic test_single();
    bus.upd_ready   = 1'b1;
    bus.req0_valid  = 1'b1;
    bus.req0_pc     = 32'h40;
    bus.req0_target = 32'h100;
    bus.req0_taken  = 1'b1;
    #1;
    n_checks++;
    if (bus.upd_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL single_no_passthru: got %b expected 0", bus.upd_valid); end
    tick();
    drive_idle();
    n_checks++;
    if (bus.upd_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL single_valid: got %b expected 1", bus.upd_valid); end
    n_checks++;
    if ({bus.upd_pc, bus.upd_target, bus.upd_taken} !== {32'h40, 32'h100, 1'b1})
      begin n_fails++; $display("[TB] FAIL single_cmd: got pc=%h tgt=%h tk=%b expected pc=40 tgt=100 tk=1", bus.upd_pc, bus.upd_target, bus.upd_taken); end
    tick();
    n_checks++;
    if (bus.upd_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL single_one_cycle: got %b expected 0", bus.upd_valid); end
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_seq [4];
    exp_seq[0] = 32'h10; exp_seq[1] = 32'h20; exp_seq[2] = 32'h14; exp_seq[3] = 32'h24;
    drive_idle();
    do_reset();
    for (int p = 0; p < 2; p++) begin
      bus.req0_valid = 1'b1; bus.req0_pc = exp_seq[2*p];
      bus.req1_valid = 1'b1; bus.req1_pc = exp_seq[2*p+1];
      tick();
      drive_idle();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (bus.upd_valid !== 1'b1 || bus.upd_pc !== exp_seq[2*p+k])
          begin n_fails++; $display("[TB] FAIL rr_order%0d: got v=%b pc=%h expected v=1 pc=%h", 2*p+k, bus.upd_valid, bus.upd_pc, exp_seq[2*p+k]); end
        tick();
      end
      n_checks++;
      if (bus.upd_valid !== 1'b0) begin n_fails++; $display("[TB] FAIL rr_drained%0d: got %b expected 0", p, bus.upd_valid); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    logic take;
    drive_idle();
    do_reset();
    bus.upd_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.req0_valid = 1'b1;
      bus.req0_pc    = 32'h100 + 32'(4 * i);
      #1;
      n_checks++;
      if (bus.req0_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL bp_ready_fill%0d: got %b expected 1", i, bus.req0_ready); end
      tick();
    end
    bus.req0_pc = 32'h110;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (bus.req0_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL bp_full_ready%0d: got %b expected 0", i, bus.req0_ready); end
      n_checks++;
      if (bus.upd_valid !== 1'b1 || bus.upd_pc !== 32'h100)
        begin n_fails++; $display("[TB] FAIL bp_stall_hold%0d: got v=%b pc=%h expected v=1 pc=100", i, bus.upd_valid, bus.upd_pc); end
      tick();
    end
    bus.upd_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      take = bus.req0_valid && bus.req0_ready;
      if (bus.upd_valid === 1'b1) got.push_back(bus.upd_pc);
      tick();
      if (take) bus.req0_valid = 1'b0;
    end
    n_checks++;
    if (got.size() != 5) begin n_fails++; $display("[TB] FAIL bp_count: got %0d expected 5", got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== 32'h100 + 32'(4 * i)) begin n_fails++; $display("[TB] FAIL bp_order%0d: got %h expected %h", i, got[i], 32'h100 + 32'(4 * i)); end
    end
  endtask

  task automatic test_sweep();
    drive_idle();
    do_reset();
    bus.upd_ready  = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_pc = 32'h200;
    bus.req1_valid = 1'b1; bus.req1_pc = 32'h300;
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.inv_all_req = 1'b1;
    #1;
    n_checks++;
    if (bus.upd_valid !== 1'b1) begin n_fails++; $display("[TB] FAIL sweep_queued: got %b expected 1", bus.upd_valid); end
    tick();
    bus.inv_all_req = 1'b0;
    bus.req0_valid  = 1'b1;
    for (int i = 0; i < NUM_SETS; i++) begin
      bus.inv_all_req = (i == 5);
      #1;
      n_checks++;
      if (bus.inv_valid !== 1'b1 || bus.inv_set !== SET_IDX_W'(i) || bus.inv_all_busy !== 1'b1)
        begin n_fails++; $display("[TB] FAIL sweep_step%0d: got inv=%b set=%0d busy=%b expected inv=1 set=%0d busy=1", i, bus.inv_valid, bus.inv_set, bus.inv_all_busy, i); end
      n_checks++;
      if ({bus.req0_ready, bus.req1_ready, bus.upd_valid} !== 3'b000)
        begin n_fails++; $display("[TB] FAIL sweep_blocked%0d: got rdy0/rdy1/upd=%b expected 000", i, {bus.req0_ready, bus.req1_ready, bus.upd_valid}); end
      tick();
    end
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if ({bus.inv_valid, bus.inv_all_busy, bus.upd_valid} !== 3'b000)
        begin n_fails++; $display("[TB] FAIL sweep_after%0d: got inv/busy/upd=%b expected 000", i, {bus.inv_valid, bus.inv_all_busy, bus.upd_valid}); end
      tick();
    end
  endtask

  task automatic test_reset_mid_sweep();
    drive_idle();
    bus.inv_all_req = 1'b1;
    tick();
    bus.inv_all_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    n_checks++;
    if (bus.inv_set !== SET_IDX_W'(7)) begin n_fails++; $display("[TB] FAIL midrst_at7: got %0d expected 7", bus.inv_set); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.inv_valid, bus.inv_all_busy} !== 2'b00 || bus.inv_set !== '0)
      begin n_fails++; $display("[TB] FAIL midrst_cleared: got inv=%b busy=%b set=%0d expected 0 0 0", bus.inv_valid, bus.inv_all_busy, bus.inv_set); end
    bus.inv_all_req = 1'b1;
    tick();
    bus.inv_all_req = 1'b0;
    n_checks++;
    if (bus.inv_valid !== 1'b1 || bus.inv_set !== '0)
      begin n_fails++; $display("[TB] FAIL midrst_restart: got inv=%b set=%0d expected 1 0", bus.inv_valid, bus.inv_set); end
    for (int i = 0; i < NUM_SETS; i++) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      bus.req0_valid  = ($urandom_range(0, 2) != 0);
      bus.req0_pc     = {$urandom()} & 32'hFFFF_FFFC;
      bus.req0_target = $urandom();
      bus.req0_taken  = $urandom_range(0, 1) == 1;
      bus.req1_valid  = ($urandom_range(0, 2) != 0);
      bus.req1_pc     = {$urandom()} & 32'hFFFF_FFFC;
      bus.req1_target = $urandom();
      bus.req1_taken  = $urandom_range(0, 1) == 1;
      bus.upd_ready   = ($urandom_range(0, 3) == 0);
      if (c % 100 > 50) bus.upd_ready = ($urandom_range(0, 3) != 0);
      bus.inv_all_req = ($urandom_range(0, 79) == 0);
      reset           = ($urandom_range(0, 249) == 0);
      #1;
      predict();
      n_checks++;
      if (bus.upd_valid !== exp_upd_valid) begin n_fails++; $display("[TB] FAIL rand_upd_valid c%0d: got %b expected %b", c, bus.upd_valid, exp_upd_valid); end
      if (exp_upd_valid) begin
        n_checks++;
        if ({bus.upd_pc, bus.upd_target, bus.upd_taken} !== exp_cmd)
          begin n_fails++; $display("[TB] FAIL rand_cmd c%0d: got pc=%h tgt=%h tk=%b expected pc=%h tgt=%h tk=%b", c, bus.upd_pc, bus.upd_target, bus.upd_taken, exp_cmd.pc, exp_cmd.target, exp_cmd.taken); end
      end
      n_checks++;
      if ({bus.req0_ready, bus.req1_ready} !== {exp_rdy0, exp_rdy1})
        begin n_fails++; $display("[TB] FAIL rand_ready c%0d: got %b%b expected %b%b", c, bus.req0_ready, bus.req1_ready, exp_rdy0, exp_rdy1); end
      n_checks++;
      if (bus.inv_valid !== m_sweep || bus.inv_all_busy !== m_sweep || bus.inv_set !== SET_IDX_W'(m_cnt))
        begin n_fails++; $display("[TB] FAIL rand_sweep c%0d: got inv=%b busy=%b set=%0d expected %b %b %0d", c, bus.inv_valid, bus.inv_all_busy, bus.inv_set, m_sweep, m_sweep, m_cnt); end
      tick();
    end
    reset = 1'b0;
    drive_idle();
  endtask

  initial begin
    q0.delete(); q1.delete();
    m_sweep = 1'b0; m_cnt = 0; m_rr = 1'b0; m_hold = 1'b0; m_hold_g = 1'b0;
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_sweep();
    test_reset_mid_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
